// File: rtl/red_pkg.sv
// Shared constants and types for the nibble-lane reduction unit.
package red_pkg;
    localparam int NIB_W  = 4;
    localparam int LANES  = 4;
    localparam int PAIR_W = 6;
    localparam int SUM_W  = 7;
    localparam int DATA_W = 16;

    typedef logic signed [NIB_W:0] lane_sum_t;
endpackage

// File: rtl/red_lane_add.sv
// One lane: exact signed sum of two 4-bit nibbles at 5-bit width.
module red_lane_add
    import red_pkg::*;
(
    input  logic [NIB_W-1:0] i_a,
    input  logic [NIB_W-1:0] i_b,
    output logic [NIB_W:0]   o_sum
);
    lane_sum_t w_a_ext;
    lane_sum_t w_b_ext;
    lane_sum_t w_sum;

    // One guard bit makes the add exact (range -16..+14), so nothing can wrap.
    assign w_a_ext = $signed({i_a[NIB_W-1], i_a});
    assign w_b_ext = $signed({i_b[NIB_W-1], i_b});
    assign w_sum   = w_a_ext + w_b_ext;
    assign o_sum   = w_sum;
endmodule

// File: rtl/red_unit.sv
// Packed-nibble reduction: four lane sums, balanced adder tree, registered copy.
module red_unit
    import red_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic              en,
    output logic [DATA_W-1:0] R,
    output logic [DATA_W-1:0] R_q,
    output logic              valid
);
    logic [NIB_W:0]            w_lane_raw [LANES];
    lane_sum_t                 w_lane     [LANES];
    logic signed [PAIR_W-1:0]  w_pair_lo;
    logic signed [PAIR_W-1:0]  w_pair_hi;
    logic signed [SUM_W-1:0]   w_total;
    logic [DATA_W-1:0]         r_rq;
    logic                      r_valid;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        red_lane_add u_lane (
            .i_a   (A[g*NIB_W +: NIB_W]),
            .i_b   (B[g*NIB_W +: NIB_W]),
            .o_sum (w_lane_raw[g])
        );
        assign w_lane[g] = $signed(w_lane_raw[g]);
    end

    // Each level grows by one bit, so the tree is exact down to -64..+56.
    assign w_pair_lo = $signed({w_lane[0][NIB_W], w_lane[0]}) + $signed({w_lane[1][NIB_W], w_lane[1]});
    assign w_pair_hi = $signed({w_lane[2][NIB_W], w_lane[2]}) + $signed({w_lane[3][NIB_W], w_lane[3]});
    assign w_total   = $signed({w_pair_lo[PAIR_W-1], w_pair_lo}) + $signed({w_pair_hi[PAIR_W-1], w_pair_hi});

    assign R = {{(DATA_W-SUM_W){w_total[SUM_W-1]}}, w_total};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rq    <= '0;
            r_valid <= 1'b0;
        end else if (en) begin
            r_rq    <= R;
            r_valid <= 1'b1;
        end
    end

    assign R_q   = r_rq;
    assign valid = r_valid;
endmodule

// File: tb/tb_red_unit.sv
// Directed and randomized checks of red_unit's combinational and registered outputs.
module tb_red_unit;
    logic        clk;
    logic        rst_n;
    logic [15:0] A;
    logic [15:0] B;
    logic        en;
    logic [15:0] R;
    logic [15:0] R_q;
    logic        valid;

    int n_vec;
    int n_err;

    red_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .en    (en),
        .R     (R),
        .R_q   (R_q),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ref_r(input logic [15:0] a, input logic [15:0] b);
        int t;
        int na;
        int nb;
        t = 0;
        for (int i = 0; i < 4; i++) begin
            na = int'((a >> (4*i)) & 16'hF);
            nb = int'((b >> (4*i)) & 16'hF);
            if (na > 7) na = na - 16;
            if (nb > 7) nb = nb - 16;
            t = t + na + nb;
        end
        return t[15:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; A = 16'h0000; B = 16'h0000;
        #12;
        n_vec++;
        if (R_q !== 16'h0000) begin n_err++; $display("FAIL reset_rq: got %h want 0000", R_q); end
        n_vec++;
        if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", valid); end
        A = 16'h1234; B = 16'h1111; #1;
        n_vec++;
        if (R !== 16'h000E) begin n_err++; $display("FAIL reset_r_tracks: got %h want 000E", R); end
        A = 16'h0000; B = 16'h0000;
        @(negedge clk);
        rst_n = 1'b1; en = 1'b1;
        tick();
        n_vec++;
        if (R !== 16'h0000) begin n_err++; $display("FAIL zero_r: got %h want 0000", R); end
        n_vec++;
        if (R_q !== 16'h0000) begin n_err++; $display("FAIL zero_rq: got %h want 0000", R_q); end
        n_vec++;
        if (valid !== 1'b1) begin n_err++; $display("FAIL zero_valid: got %b want 1", valid); end
        en = 1'b0;
    endtask

    task automatic test_comb_vectors();
        logic [15:0] va [6];
        logic [15:0] vb [6];
        logic [15:0] vr [6];
        va = '{16'h1234, 16'hF000, 16'hABCD, 16'hFFFF, 16'h8888, 16'h7777};
        vb = '{16'h1111, 16'h0F00, 16'h1234, 16'hFFFF, 16'h8888, 16'h7777};
        vr = '{16'h000E, 16'hFFFE, 16'hFFF8, 16'hFFF8, 16'hFFC0, 16'h0038};
        en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            A = va[i]; B = vb[i]; #1;
            n_vec++;
            if (R !== vr[i]) begin
                n_err++;
                $display("FAIL comb_%0d: A=%h B=%h got %h want %h", i, va[i], vb[i], R, vr[i]);
            end
        end
        // Lane isolation: a carry out of lane 0 must not reach lane 1.
        A = 16'h0007; B = 16'h0007; #1;
        n_vec++;
        if (R !== 16'h000E) begin n_err++; $display("FAIL lane_carry: got %h want 000E", R); end
        A = 16'h0070; B = 16'h0090; #1;
        n_vec++;
        if (R !== 16'h0000) begin n_err++; $display("FAIL lane_mixed: got %h want 0000", R); end
    endtask

    task automatic test_capture_hold();
        @(negedge clk);
        A = 16'h1234; B = 16'h1111; en = 1'b1;
        tick();
        n_vec++;
        if (R_q !== 16'h000E) begin n_err++; $display("FAIL capture_rq: got %h want 000E", R_q); end
        en = 1'b0; A = 16'h8888; B = 16'h8888;
        tick();
        n_vec++;
        if (R_q !== 16'h000E) begin n_err++; $display("FAIL hold_rq: got %h want 000E", R_q); end
        n_vec++;
        if (valid !== 1'b1) begin n_err++; $display("FAIL hold_valid: got %b want 1", valid); end
        n_vec++;
        if (R !== 16'hFFC0) begin n_err++; $display("FAIL hold_r: got %h want FFC0", R); end
        // Mid-cycle input change with en high must not reach R_q before the edge.
        en = 1'b1; A = 16'h7777; B = 16'h7777; #2;
        n_vec++;
        if (R_q !== 16'h000E) begin n_err++; $display("FAIL between_edges_rq: got %h want 000E", R_q); end
        tick();
        n_vec++;
        if (R_q !== 16'h0038) begin n_err++; $display("FAIL next_capture_rq: got %h want 0038", R_q); end
        en = 1'b0;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        rst_n = 1'b0; #1;
        n_vec++;
        if (R_q !== 16'h0000) begin n_err++; $display("FAIL async_rst_rq: got %h want 0000", R_q); end
        n_vec++;
        if (valid !== 1'b0) begin n_err++; $display("FAIL async_rst_valid: got %b want 0", valid); end
        A = 16'hABCD; B = 16'h1234; en = 1'b1; #1;
        n_vec++;
        if (R !== 16'hFFF8) begin n_err++; $display("FAIL async_rst_r: got %h want FFF8", R); end
        tick();
        n_vec++;
        if (valid !== 1'b0) begin n_err++; $display("FAIL rst_no_capture: got %b want 0", valid); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_vec++;
        if (R_q !== 16'hFFF8) begin n_err++; $display("FAIL post_rst_rq: got %h want FFF8", R_q); end
        n_vec++;
        if (valid !== 1'b1) begin n_err++; $display("FAIL post_rst_valid: got %b want 1", valid); end
    endtask

    task automatic test_random();
        logic [15:0] exp;
        en = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            A = 16'($urandom); B = 16'($urandom);
            exp = ref_r(A, B);
            #1;
            n_vec++;
            if (R !== exp) begin n_err++; $display("FAIL rand_r_%0d: A=%h B=%h got %h want %h", i, A, B, R, exp); end
            tick();
            n_vec++;
            if (R_q !== exp) begin n_err++; $display("FAIL rand_rq_%0d: got %h want %h", i, R_q, exp); end
        end
        en = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_comb_vectors();
        test_capture_hold();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/red_unit.md
RED_UNIT -- requirements
Module: red_unit

Interface
REQ-001: Parameters: none; all widths fixed.
REQ-002: clk  input  1  single system clock; rising edge active.
REQ-003: rst_n  input  1  reset, asynchronous, active-low.
REQ-004: A  input  16  operand A, four packed signed 4-bit nibbles: A[3:0], A[7:4], A[11:8], A[15:12].
REQ-005: B  input  16  operand B, same nibble packing as A.
REQ-006: en  input  1  capture enable for the registered result.
REQ-007: R  output  16  combinational reduction result, two's complement.
REQ-008: R_q  output  16  registered copy of R.
REQ-009: valid  output  1  high while R_q holds a captured result.

Function
REQ-010: Per lane i (0..3): s_i = sext(A nibble i) + sext(B nibble i), computed at 5-bit signed width; range -16..+14; no lane saturation or wrap.
REQ-011: Total = s0+s1+s2+s3, computed at 7-bit signed width; range -64..+56; no overflow is possible.
REQ-012: R = total sign-extended to 16 bits.
REQ-013: R is purely combinational from A and B; zero latency; R is independent of clk, rst_n and en.
REQ-014: R settles within one simulation step of an input change; no latches; no internal state on the R path.
REQ-015: On a rising clk edge with en=1: R_q <= R, valid <= 1.
REQ-016: On a rising clk edge with en=0: R_q and valid hold their values.
REQ-017: R_q is updated on the clk edge only; A or B changes between edges have no effect on R_q.
REQ-018: Nibble lanes are independent; no carry propagates from lane i into lane i+1.
REQ-019: Reduction structure: two pairwise 6-bit adds (s0+s1, s2+s3), then one 7-bit add.

Reset
REQ-020: rst_n=0 immediately forces R_q=16'h0000 and valid=0, regardless of clk.
REQ-021: Reset deassertion takes effect at the next clk edge; the first capture occurs on the first rising edge with rst_n=1 and en=1.
REQ-022: Reset asserted mid-operation discards the held result.
REQ-023: R continues to track A and B during reset.

Structure
REQ-024: Shared package red_pkg holds:
  - constants NIB_W=4, LANES=4, SUM_W=7, DATA_W=16;
  - typedef for a 5-bit signed lane sum.
REQ-025: One sub-module, red_lane_add:
  - inputs: two 4-bit signed nibbles;
  - output: 5-bit signed sum;
  - instantiated four times (one per lane).
REQ-026: The top level holds the adder tree, the sign extension and the output register.

Verification
REQ-027: A=0000, B=0000 -> R=0000; after a clk edge with en=1, R_q=0000 and valid=1.
REQ-028: Lane and sign checks:
  - A=1234, B=1111 -> R=000E;
  - A=F000, B=0F00 -> R=FFFE.
REQ-029: A=ABCD, B=1234 -> R=FFF8; A=FFFF, B=FFFF -> R=FFF8.
REQ-030: Extremes:
  - A=8888, B=8888 -> R=FFC0 (-64);
  - A=7777, B=7777 -> R=0038 (+56).
REQ-031: Register and reset sequence:
  1. Capture A=1234, B=1111 with en=1 -> R_q=000E.
  2. Change the inputs with en=0 -> R_q holds 000E.
  3. Assert rst_n=0 between clock edges -> R_q=0000 and valid=0 immediately; R still tracks the inputs.
REQ-032: Random: at least 1000 random A/B pairs; R and R_q checked against a reference model of REQ-010 to REQ-012.
